// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I opcode and funct3 codes,
// fault cause codes, FSM state encoding and an immediate-extraction helper.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_MISAL   = 2'd1,
    FAULT_ILLEGAL = 2'd2,
    FAULT_TIMEOUT = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Stores (opcode bit 5 set) use the split S-type immediate, loads the I-type one.
  function automatic logic [31:0] imm_of(input logic [31:0] instr);
    if (instr[5]) begin
      return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    end
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
//  bus_addr   word-aligned address        bus_lanes  byte enables
//  bus_dout   lane-shifted write data     bus_din    read data from memory
//  bus_wr     1 = write                   bus_valid  request, held until bus_ready
//  bus_ready  completion from memory
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_lanes;
  logic [31:0]       bus_dout;
  logic [31:0]       bus_din;
  logic              bus_wr;
  logic              bus_valid;
  logic              bus_ready;

  modport master (
    output bus_addr, bus_lanes, bus_dout, bus_wr, bus_valid,
    input  bus_din, bus_ready
  );

  modport slave (
    input  bus_addr, bus_lanes, bus_dout, bus_wr, bus_valid,
    output bus_din, bus_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//  ea_lo_i      low two bits of the effective address
//  funct3_i     access size/sign code
//  r2_i         store data register
//  bus_din_i    read data from the bus
//  lanes_o      byte enables for the access
//  dout_o       store data replicated across the lanes
//  misal_o      access not naturally aligned
//  load_data_o  selected lane of bus_din_i, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  ea_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] r2_i,
  input  logic [31:0] bus_din_i,
  output logic [3:0]  lanes_o,
  output logic [31:0] dout_o,
  output logic        misal_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lanes ignore ea[0], so a tolerated misaligned half stays inside the word.
  always_comb begin
    lanes_o = 4'b1111;
    dout_o  = r2_i;
    misal_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        lanes_o = 4'b0001 << ea_lo_i;
        dout_o  = {4{r2_i[7:0]}};
      end
      2'b01: begin
        lanes_o = 4'b0011 << {ea_lo_i[1], 1'b0};
        dout_o  = {2{r2_i[15:0]}};
        misal_o = ea_lo_i[0];
      end
      default: begin
        lanes_o = 4'b1111;
        dout_o  = r2_i;
        misal_o = |ea_lo_i;
      end
    endcase
  end

  assign byte_sel = bus_din_i[{ea_lo_i, 3'b000} +: 8];
  assign half_sel = bus_din_i[{ea_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = bus_din_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'h000000, byte_sel};
      F3_HU:   load_data_o = {16'h0000, half_sel};
      default: load_data_o = bus_din_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes RV32I loads/stores, forms the effective address,
// runs one bus transaction per request and returns extended load data.
//  clk, rst_n    clock and asynchronous active-low reset
//  instr/r1/r2   instruction, base register, store data (held while valid)
//  valid/ready   request in, one-cycle completion pulse out
//  read_result   extended load data (0 for stores), valid with ready
//  fault         access not (fully) performed, valid with ready
//  fault_cause   0 none, 1 misaligned, 2 illegal, 3 bus timeout
//  bus           data-bus master port
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT     = 255,
  parameter int ALLOW_MISAL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic        valid,
  output logic        ready,
  output logic [31:0] read_result,
  output logic        fault,
  output logic [1:0]  fault_cause,
  lsu_if.master       bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q;
  logic              ready_q;
  logic [31:0]       read_result_q;
  logic              fault_q;
  fault_e            cause_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        lanes_q;
  logic [31:0]       dout_q;
  logic              wr_q;
  logic              bus_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        ea_lo_q;
  logic [2:0]        funct3_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] ea_d;
  logic        is_load;
  logic        is_store;
  logic        misal_hit;
  logic        timeout_hit;
  logic [1:0]  align_ea_lo;
  logic [2:0]  align_funct3;
  logic [3:0]  align_lanes;
  logic [31:0] align_dout;
  logic        align_misal;
  logic [31:0] align_load;
  logic        unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // 32-bit add wraps naturally; only the low ADDR_W bits reach the bus.
  assign ea_d   = r1 + imm_of(instr);
  assign unused_instr_bits = ^instr[19:15];

  always_comb begin
    is_load  = (opcode == OPC_LOAD) &&
               (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    is_store = (opcode == OPC_STORE) && (funct3 inside {F3_B, F3_H, F3_W});
  end

  assign misal_hit   = align_misal && (ALLOW_MISAL == 0);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // While a transaction is in flight the aligner sees the latched address bits
  // and size, so load extraction does not depend on the caller's held inputs.
  assign align_ea_lo  = (state_q == ST_BUS) ? ea_lo_q  : ea_d[1:0];
  assign align_funct3 = (state_q == ST_BUS) ? funct3_q : funct3;

  lsu_align u_align (
    .ea_lo_i     (align_ea_lo),
    .funct3_i    (align_funct3),
    .r2_i        (r2),
    .bus_din_i   (bus.bus_din),
    .lanes_o     (align_lanes),
    .dout_o      (align_dout),
    .misal_o     (align_misal),
    .load_data_o (align_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b0;
      read_result_q <= '0;
      fault_q       <= 1'b0;
      cause_q       <= FAULT_NONE;
      addr_q        <= '0;
      lanes_q       <= '0;
      dout_q        <= '0;
      wr_q          <= 1'b0;
      bus_valid_q   <= 1'b0;
      cnt_q         <= '0;
      ea_lo_q       <= '0;
      funct3_q      <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            ea_lo_q  <= ea_d[1:0];
            funct3_q <= funct3;
            if (!is_load && !is_store) begin
              fault_q       <= 1'b1;
              cause_q       <= FAULT_ILLEGAL;
              read_result_q <= '0;
              ready_q       <= 1'b1;
              state_q       <= ST_RESP;
            end else if (misal_hit) begin
              fault_q       <= 1'b1;
              cause_q       <= FAULT_MISAL;
              read_result_q <= '0;
              ready_q       <= 1'b1;
              state_q       <= ST_RESP;
            end else begin
              addr_q      <= {ea_d[ADDR_W-1:2], 2'b00};
              lanes_q     <= align_lanes;
              dout_q      <= align_dout;
              wr_q        <= is_store;
              bus_valid_q <= 1'b1;
              fault_q     <= 1'b0;
              cause_q     <= FAULT_NONE;
              cnt_q       <= '0;
              state_q     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // A completion in the same cycle the counter expires takes priority.
          if (bus.bus_ready) begin
            bus_valid_q   <= 1'b0;
            read_result_q <= wr_q ? 32'h0 : align_load;
            ready_q       <= 1'b1;
            state_q       <= ST_RESP;
          end else if (timeout_hit) begin
            bus_valid_q   <= 1'b0;
            fault_q       <= 1'b1;
            cause_q       <= FAULT_TIMEOUT;
            read_result_q <= '0;
            ready_q       <= 1'b1;
            state_q       <= ST_RESP;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          // valid is deliberately not looked at here so a held request cannot restart.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready         = ready_q;
  assign read_result   = read_result_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_lanes = lanes_q;
  assign bus.bus_dout  = dout_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_valid = bus_valid_q;

endmodule
